pll_reset_sequencer: RTL and testbench

Controls the PLL from the reset side: drives the PLL's reset input, watches its lock output, and releases the core's system reset only after lock has stayed stable. It sits in the 50 MHz reference domain, beside the PLL instance. It retries a PLL that fails to lock, re-sequences on loss of lock, and reports lock statistics to the OSD/status logic.

---
 rtl/pll_reset_sequencer.sv | 129 ++++++++++++
 tb/tb_pll_reset_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock and then releases the core reset.
// It retries a PLL that fails to lock, re-sequences on loss of lock and keeps lock statistics.
module pll_reset_sequencer #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRY     = 3,
   parameter int CNT_W         = 16
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       ext_reset_req,
   output logic       pll_rst,
   output logic       sys_reset,
   output logic       locked_sync,
   output logic       lock_fail,
   output logic [7:0] lost_cnt
);

   typedef enum logic [1:0] {
      PLL_RESET = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [3:0]       retry_cnt_reg, retry_cnt_next;
   logic [7:0]       lost_cnt_reg, lost_cnt_next;
   logic             lock_fail_reg, lock_fail_next;
   logic             pll_rst_reg, sys_reset_reg;
   logic             sync1_reg, sync2_reg;
   logic             locked_s;

   assign locked_s    = sync2_reg;
   assign locked_sync = sync2_reg;
   assign pll_rst     = pll_rst_reg;
   assign sys_reset   = sys_reset_reg;
   assign lock_fail   = lock_fail_reg;
   assign lost_cnt    = lost_cnt_reg;

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      retry_cnt_next = retry_cnt_reg;
      lost_cnt_next  = lost_cnt_reg;
      lock_fail_next = lock_fail_reg;

      case (state_reg)
         PLL_RESET: begin
            if (cnt_reg == RST_LAST)
               state_next = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            // A lock seen on the timeout cycle still wins over the retry.
            if (locked_s)
               state_next = STABLE;
            else if (cnt_reg == TIMEOUT_LAST) begin
               state_next = PLL_RESET;
               if (retry_cnt_reg != 4'hF)
                  retry_cnt_next = retry_cnt_reg + 4'd1;
            end
         end
         STABLE: begin
            if (!locked_s)
               state_next = WAIT_LOCK;
            else if (cnt_reg == STABLE_LAST) begin
               state_next     = RUN;
               retry_cnt_next = 4'd0;
            end
         end
         RUN: begin
            if (!locked_s) begin
               state_next = PLL_RESET;
               if (lost_cnt_reg != 8'hFF)
                  lost_cnt_next = lost_cnt_reg + 8'd1;
            end
         end
         default: state_next = PLL_RESET;
      endcase

      // A user reset overrides every transition and leaves the statistics untouched.
      if (ext_reset_req) begin
         state_next     = PLL_RESET;
         retry_cnt_next = retry_cnt_reg;
         lost_cnt_next  = lost_cnt_reg;
      end

      if (retry_cnt_next == RETRY_LIMIT)
         lock_fail_next = 1'b1;

      if (ext_reset_req || (state_next != state_reg))
         cnt_next = '0;
      else if (state_reg != RUN)
         cnt_next = cnt_reg + 1'b1;
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_reg     <= PLL_RESET;
         cnt_reg       <= '0;
         retry_cnt_reg <= 4'd0;
         lost_cnt_reg  <= 8'd0;
         lock_fail_reg <= 1'b0;
         pll_rst_reg   <= 1'b1;
         sys_reset_reg <= 1'b1;
         sync1_reg     <= 1'b0;
         sync2_reg     <= 1'b0;
      end else begin
         sync1_reg     <= pll_locked;
         sync2_reg     <= sync1_reg;
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         retry_cnt_reg <= retry_cnt_next;
         lost_cnt_reg  <= lost_cnt_next;
         lock_fail_reg <= lock_fail_next;
         pll_rst_reg   <= (state_next == PLL_RESET);
         sys_reset_reg <= (state_next != RUN);
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: a phase/age reference model queues the expected outputs per
// edge and an independent monitor compares them against the DUT one edge later.
module tb_pll_reset_sequencer;

   localparam int RST_CYCLES    = 4;
   localparam int LOCK_TIMEOUT  = 20;
   localparam int STABLE_CYCLES = 8;
   localparam int MAX_RETRY     = 3;

   localparam int P_RESET  = 0;
   localparam int P_WAIT   = 1;
   localparam int P_STABLE = 2;
   localparam int P_RUN    = 3;

   logic       refclk = 1'b0;
   logic       rst;
   logic       pll_locked;
   logic       ext_reset_req;
   logic       pll_rst;
   logic       sys_reset;
   logic       locked_sync;
   logic       lock_fail;
   logic [7:0] lost_cnt;

   typedef struct packed {
      logic       pll_rst;
      logic       sys_reset;
      logic       locked_sync;
      logic       lock_fail;
      logic [7:0] lost_cnt;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model: which phase we are in, how many edges we have spent there,
   // the raw lock history seen by the synchronizer, and unbounded statistics.
   int   m_phase;
   int   m_age;
   int   m_misses;
   int   m_lost;
   bit   m_fail;
   bit   m_s1;
   bit   m_s2;

   always #5 refclk = ~refclk;

   pll_reset_sequencer #(
      .RST_CYCLES   (RST_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .STABLE_CYCLES(STABLE_CYCLES),
      .MAX_RETRY    (MAX_RETRY),
      .CNT_W        (16)
   ) dut (
      .refclk       (refclk),
      .rst          (rst),
      .pll_locked   (pll_locked),
      .ext_reset_req(ext_reset_req),
      .pll_rst      (pll_rst),
      .sys_reset    (sys_reset),
      .locked_sync  (locked_sync),
      .lock_fail    (lock_fail),
      .lost_cnt     (lost_cnt)
   );

   function automatic void check(string name, int act, int req);
      tests++;
      if (act != req) begin
         fails++;
         if (fails <= 40)
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
      end
   endfunction

   function automatic void model_reset();
      m_phase  = P_RESET;
      m_age    = 0;
      m_misses = 0;
      m_lost   = 0;
      m_fail   = 1'b0;
      m_s1     = 1'b0;
      m_s2     = 1'b0;
   endfunction

   function automatic void enter(int p);
      m_phase = p;
      m_age   = 0;
   endfunction

   // One rising edge of refclk with the given inputs.
   function automatic void model_edge(bit locked_in, bit ext, bit rst_in);
      bit seen;
      if (rst_in) begin
         model_reset();
         return;
      end
      seen  = m_s2;
      m_s2  = m_s1;
      m_s1  = locked_in;
      m_age = m_age + 1;
      if (ext) begin
         enter(P_RESET);
         return;
      end
      if (m_phase == P_RESET) begin
         if (m_age >= RST_CYCLES) enter(P_WAIT);
      end else if (m_phase == P_WAIT) begin
         if (seen) enter(P_STABLE);
         else if (m_age >= LOCK_TIMEOUT) begin
            m_misses = m_misses + 1;
            if (m_misses >= MAX_RETRY) m_fail = 1'b1;
            enter(P_RESET);
         end
      end else if (m_phase == P_STABLE) begin
         if (!seen) enter(P_WAIT);
         else if (m_age >= STABLE_CYCLES) begin
            m_misses = 0;
            enter(P_RUN);
         end
      end else begin
         if (!seen) begin
            m_lost = m_lost + 1;
            enter(P_RESET);
         end
      end
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.pll_rst     = (m_phase == P_RESET);
      e.sys_reset   = (m_phase != P_RUN);
      e.locked_sync = m_s2;
      e.lock_fail   = m_fail;
      e.lost_cnt    = (m_lost > 255) ? 8'd255 : 8'(m_lost);
      return e;
   endfunction

   // Drive one edge worth of stimulus and queue what the DUT must show after it.
   task automatic step(input bit locked_in, input bit ext);
      pll_locked    = locked_in;
      ext_reset_req = ext;
      model_edge(locked_in, ext, rst);
      exp_q.push_back(model_out());
      @(posedge refclk);
      @(negedge refclk);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge refclk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pll_rst",     int'(pll_rst),     int'(e.pll_rst));
            check("sys_reset",   int'(sys_reset),   int'(e.sys_reset));
            check("locked_sync", int'(locked_sync), int'(e.locked_sync));
            check("lock_fail",   int'(lock_fail),   int'(e.lock_fail));
            check("lost_cnt",    int'(lost_cnt),    int'(e.lost_cnt));
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      int lvl;
      int run_len;
      rst           = 1'b1;
      pll_locked    = 1'b0;
      ext_reset_req = 1'b0;
      model_reset();

      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      $display("[TB] reset hold: pll_rst=%0b sys_reset=%0b", pll_rst, sys_reset);

      // Normal start: lock arrives at edge 10, release after edge 20.
      rst = 1'b0;
      for (int e = 1; e <= 30; e++) begin
         step(e >= 10, 1'b0);
         if (e == 3)  check("start_pll_rst_e3",  int'(pll_rst), 1);
         if (e == 4)  check("start_pll_rst_e4",  int'(pll_rst), 0);
         if (e == 19) check("start_sys_rst_e19", int'(sys_reset), 1);
         if (e == 20) check("start_sys_rst_e20", int'(sys_reset), 0);
      end
      $display("[TB] normal start: sys_reset=%0b lost_cnt=%0d", sys_reset, lost_cnt);

      // Three lock timeouts set lock_fail; a later lock still reaches RUN.
      step(1'b0, 1'b1);
      for (int i = 0; i < 77; i++) step(1'b0, 1'b0);
      check("timeout_lock_fail", int'(lock_fail), 1);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
      check("timeout_relock_run", int'(sys_reset), 0);
      check("timeout_fail_sticky", int'(lock_fail), 1);
      $display("[TB] timeout retry: lock_fail=%0b sys_reset=%0b", lock_fail, sys_reset);

      // Unstable lock: drops back to WAIT_LOCK without another PLL reset.
      step(1'b0, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      check("unstable_no_pll_rst", int'(pll_rst), 0);
      check("unstable_sys_held",   int'(sys_reset), 1);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
      check("unstable_release", int'(sys_reset), 0);
      $display("[TB] unstable lock: sys_reset=%0b", sys_reset);

      // User reset on the same edge the lock loss is seen in RUN.
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      check("simul_pll_rst",  int'(pll_rst), 1);
      check("simul_lost_cnt", int'(lost_cnt), 0);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
      $display("[TB] simultaneous ext+loss: lost_cnt=%0d", lost_cnt);

      // 300 lock losses in RUN; the counter saturates.
      for (int n = 0; n < 300; n++) begin
         run_len = (n == 0) ? 3 : int'($urandom_range(1, 4));
         for (int j = 0; j < run_len; j++) begin
            step(1'b0, 1'b0);
            if (n == 0 && j == 1) check("loss_sys_e1", int'(sys_reset), 0);
            if (n == 0 && j == 2) begin
               check("loss_sys_e2", int'(sys_reset), 1);
               check("loss_lost_1", int'(lost_cnt), 1);
            end
         end
         run_len = int'($urandom_range(18, 24));
         for (int j = 0; j < run_len; j++) step(1'b1, 1'b0);
      end
      check("loss_lost_sat", int'(lost_cnt), 255);
      $display("[TB] repeated loss: lost_cnt=%0d", lost_cnt);

      // Random lock behaviour with occasional user resets.
      lvl = 1;
      for (int n = 0; n < 60; n++) begin
         lvl     = 1 - lvl;
         run_len = int'($urandom_range(1, 40));
         for (int j = 0; j < run_len; j++) step(lvl != 0, $urandom_range(0, 49) == 0);
      end
      $display("[TB] random phase: lost_cnt=%0d lock_fail=%0b", lost_cnt, lock_fail);

      // Asynchronous reset in the middle of STABLE.
      step(1'b1, 1'b1);
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
      check("pre_async_lost",      int'(lost_cnt), 255);
      check("pre_async_lock_fail", int'(lock_fail), 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_pll_rst",     int'(pll_rst), 1);
      check("async_sys_reset",   int'(sys_reset), 1);
      check("async_locked_sync", int'(locked_sync), 0);
      check("async_lock_fail",   int'(lock_fail), 0);
      check("async_lost_cnt",    int'(lost_cnt), 0);
      model_reset();
      @(negedge refclk);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
      check("post_async_run", int'(sys_reset), 0);
      $display("[TB] async reset mid-STABLE: sys_reset=%0b lost_cnt=%0d", sys_reset, lost_cnt);

      @(posedge refclk);
      #3;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
